// File: rtl/ctrl_barrier_arbiter_if.sv
// ctrl_barrier_arbiter_if
//   Handshake bundle between the ingress taps / requesters and the barrier release arbiter.
//   Signals:
//     s_inc        per-port event-entered pulse
//     m_req        per-port release request (level)
//     m_gnt        one-hot grant pulse from the arbiter
//     m_gnt_id     index of the granted port, valid with |m_gnt
//     err_overflow sticky flag: an event was dropped at the serial-number window limit
//   Modports: master = requester side, slave = arbiter side.
interface ctrl_barrier_arbiter_if #(
    parameter int unsigned PORT_COUNT = 2
);
    localparam int unsigned ID_W = (PORT_COUNT > 1) ? $clog2(PORT_COUNT) : 1;

    logic [PORT_COUNT-1:0] s_inc;
    logic [PORT_COUNT-1:0] m_req;
    logic [PORT_COUNT-1:0] m_gnt;
    logic [ID_W-1:0]       m_gnt_id;
    logic                  err_overflow;

    modport master (
        output s_inc,
        output m_req,
        input  m_gnt,
        input  m_gnt_id,
        input  err_overflow
    );

    modport slave (
        input  s_inc,
        input  m_req,
        output m_gnt,
        output m_gnt_id,
        output err_overflow
    );
endinterface

// File: rtl/ctrl_barrier_arbiter.sv
// ctrl_barrier_arbiter
//   Cross-port release arbiter for ctrl-barrier ordering. Counts events entering on each port
//   and grants a requesting port release of its next event only once every port has received
//   an event past that point. At most one grant every two cycles, round-robin among eligible
//   ports.
//   Ports:
//     clk   rising-edge clock
//     rst   asynchronous active-low reset
//     bus   ctrl_barrier_arbiter_if.slave (s_inc, m_req in; m_gnt, m_gnt_id, err_overflow out)
//   Optional build macro CTRL_BARRIER_ARB_STATS_EN adds:
//     stat_grants  total grants issued (wrapping)
//     stat_stall   cycles in arbitration with a request but nothing eligible (wrapping)
module ctrl_barrier_arbiter #(
    parameter int unsigned PORT_COUNT = 2,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    ctrl_barrier_arbiter_if.slave  bus
`ifdef CTRL_BARRIER_ARB_STATS_EN
    ,
    output logic [31:0]            stat_grants,
    output logic [31:0]            stat_stall
`endif
);
    localparam int unsigned ID_W = (PORT_COUNT > 1) ? $clog2(PORT_COUNT) : 1;
    // Serial-number window: largest forward distance treated as "ahead".
    localparam logic [CNT_W-1:0] LIMIT = {1'b0, {(CNT_W-1){1'b1}}};

    typedef enum logic [0:0] {StArb, StGnt} state_e;

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      in_cnt_q  [PORT_COUNT];
    logic [CNT_W-1:0]      in_cnt_d  [PORT_COUNT];
    logic [CNT_W-1:0]      out_cnt_q [PORT_COUNT];
    logic [CNT_W-1:0]      out_cnt_d [PORT_COUNT];
    logic [ID_W-1:0]       rr_q, rr_d;
    logic [PORT_COUNT-1:0] gnt_q, gnt_d;
    logic [ID_W-1:0]       gnt_id_q, gnt_id_d;
    logic                  err_q, err_d;

    logic [PORT_COUNT-1:0] elig;
    logic [PORT_COUNT-1:0] drop;
    logic                  pick_found;
    logic [ID_W-1:0]       pick_idx;
    int unsigned           pos;
    int unsigned           best_pos;

    function automatic logic [CNT_W-1:0] serial_dist(logic [CNT_W-1:0] a, logic [CNT_W-1:0] b);
        return a - b;
    endfunction

    // Port i may release once every port has an event strictly past out_cnt[i], within the
    // window. An increment on port i is dropped if it would push i beyond the window of any
    // port's release point.
    always_comb begin
        elig = '0;
        drop = '0;
        for (int i = 0; i < PORT_COUNT; i++) begin
            elig[i] = bus.m_req[i];
            for (int j = 0; j < PORT_COUNT; j++) begin
                if (serial_dist(in_cnt_q[j], out_cnt_q[i]) == '0 ||
                    serial_dist(in_cnt_q[j], out_cnt_q[i]) > LIMIT) begin
                    elig[i] = 1'b0;
                end
                if (serial_dist(in_cnt_q[i], out_cnt_q[j]) == LIMIT) begin
                    drop[i] = 1'b1;
                end
            end
        end
    end

    // Round-robin pick: smallest rotational distance from rr_q wins.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        pos        = 0;
        best_pos   = PORT_COUNT;
        for (int unsigned i = 0; i < PORT_COUNT; i++) begin
            pos = (i + PORT_COUNT - 32'(rr_q)) % PORT_COUNT;
            if (elig[i] && pos < best_pos) begin
                best_pos   = pos;
                pick_idx   = ID_W'(i);
                pick_found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        gnt_d    = '0;
        gnt_id_d = gnt_id_q;
        rr_d     = rr_q;
        err_d    = err_q | (|(bus.s_inc & drop));
        for (int j = 0; j < PORT_COUNT; j++) begin
            in_cnt_d[j]  = (bus.s_inc[j] && !drop[j]) ? in_cnt_q[j] + 1'b1 : in_cnt_q[j];
            out_cnt_d[j] = out_cnt_q[j];
        end
        unique case (state_q)
            StArb: begin
                if (pick_found) begin
                    gnt_d               = PORT_COUNT'(1) << pick_idx;
                    gnt_id_d            = pick_idx;
                    out_cnt_d[pick_idx] = out_cnt_q[pick_idx] + 1'b1;
                    rr_d                = (pick_idx == ID_W'(PORT_COUNT - 1)) ? '0
                                                                              : pick_idx + 1'b1;
                    state_d             = StGnt;
                end
            end
            StGnt: begin
                state_d = StArb;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StArb;
            rr_q     <= '0;
            gnt_q    <= '0;
            gnt_id_q <= '0;
            err_q    <= 1'b0;
            for (int j = 0; j < PORT_COUNT; j++) begin
                in_cnt_q[j]  <= '0;
                out_cnt_q[j] <= '0;
            end
        end else begin
            state_q  <= state_d;
            rr_q     <= rr_d;
            gnt_q    <= gnt_d;
            gnt_id_q <= gnt_id_d;
            err_q    <= err_d;
            for (int j = 0; j < PORT_COUNT; j++) begin
                in_cnt_q[j]  <= in_cnt_d[j];
                out_cnt_q[j] <= out_cnt_d[j];
            end
        end
    end

    assign bus.m_gnt        = gnt_q;
    assign bus.m_gnt_id     = gnt_id_q;
    assign bus.err_overflow = err_q;

`ifdef CTRL_BARRIER_ARB_STATS_EN
    logic [31:0] stat_grants_q;
    logic [31:0] stat_stall_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_grants_q <= '0;
            stat_stall_q  <= '0;
        end else begin
            if (state_q == StArb && pick_found) begin
                stat_grants_q <= stat_grants_q + 32'd1;
            end
            if (state_q == StArb && (|bus.m_req) && !(|elig)) begin
                stat_stall_q <= stat_stall_q + 32'd1;
            end
        end
    end

    assign stat_grants = stat_grants_q;
    assign stat_stall  = stat_stall_q;
`endif
endmodule

// File: tb/tb_ctrl_barrier_arbiter.sv
module tb_ctrl_barrier_arbiter;
    localparam int unsigned P     = 2;
    localparam int unsigned W     = 4;
    localparam int          LIMIT = (1 << (W - 1)) - 1;

    logic clk = 1'b0;
    logic rst = 1'b0;

    ctrl_barrier_arbiter_if #(.PORT_COUNT(P)) bus_if ();

`ifdef CTRL_BARRIER_ARB_STATS_EN
    logic [31:0] stat_grants;
    logic [31:0] stat_stall;
`endif

    ctrl_barrier_arbiter #(
        .PORT_COUNT(P),
        .CNT_W     (W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus_if)
`ifdef CTRL_BARRIER_ARB_STATS_EN
        ,
        .stat_grants(stat_grants),
        .stat_stall (stat_stall)
`endif
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int errors   = 0;
    int gnt_seen = 0;
    int seen_ids[$];
    int exp_q[$];

    // Reference model: unbounded event / release counts per port.
    int ev  [P];
    int rel [P];
    bit cool;
    int rr;
    bit err_m;

    function automatic void model_reset();
        for (int i = 0; i < P; i++) begin
            ev[i]  = 0;
            rel[i] = 0;
        end
        cool  = 1'b0;
        rr    = 0;
        err_m = 1'b0;
        exp_q.delete();
    endfunction

    function automatic void model_step();
        bit el [P];
        bit dr [P];
        int k;
        for (int i = 0; i < P; i++) begin
            el[i] = bus_if.m_req[i];
            dr[i] = 1'b0;
            for (int j = 0; j < P; j++) begin
                // port j must have an event beyond port i's release point, within the window
                if (!(ev[j] - rel[i] >= 1 && ev[j] - rel[i] <= LIMIT)) el[i] = 1'b0;
                if (ev[i] - rel[j] == LIMIT) dr[i] = 1'b1;
            end
        end
        for (int j = 0; j < P; j++) begin
            if (bus_if.s_inc[j]) begin
                if (dr[j]) err_m = 1'b1;
                else ev[j]++;
            end
        end
        if (cool) begin
            cool = 1'b0;
        end else begin
            for (int off = 0; off < P; off++) begin
                k = (rr + off) % P;
                if (el[k]) begin
                    exp_q.push_back(k);
                    rel[k]++;
                    rr   = (k + 1) % P;
                    cool = 1'b1;
                    break;
                end
            end
        end
    endfunction

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) model_reset();
            else model_step();
        end
    end

    // Monitor / scoreboard
    always @(negedge clk) begin : mon
        int e;
        logic [P-1:0] oh;
        checks++;
        if (bus_if.err_overflow !== err_m) begin
            errors++;
            $display("FAIL err_overflow: got %0b want %0b", bus_if.err_overflow, err_m);
        end
        if (bus_if.m_gnt !== '0) begin
            gnt_seen++;
            seen_ids.push_back(int'(bus_if.m_gnt_id));
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_grant: got m_gnt=%b id=%0d want none",
                         bus_if.m_gnt, bus_if.m_gnt_id);
            end else begin
                e     = exp_q.pop_front();
                oh    = '0;
                oh[e] = 1'b1;
                if (bus_if.m_gnt !== oh || int'(bus_if.m_gnt_id) != e) begin
                    errors++;
                    $display("FAIL grant: got m_gnt=%b id=%0d want m_gnt=%b id=%0d",
                             bus_if.m_gnt, bus_if.m_gnt_id, oh, e);
                end
            end
        end else if (exp_q.size() != 0) begin
            checks++;
            errors++;
            e = exp_q.pop_front();
            $display("FAIL missing_grant: got none want id=%0d", e);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    task automatic check_int(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    task automatic drive(input logic [P-1:0] inc, input logic [P-1:0] req);
        bus_if.s_inc = inc;
        bus_if.m_req = req;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus_if.s_inc = '0;
        bus_if.m_req = '0;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    int base;
    int pct;
    logic [P-1:0] inc;

    initial begin
        bus_if.s_inc = '0;
        bus_if.m_req = '0;
        do_reset();
        check_int("reset_gnt", int'(bus_if.m_gnt), 0);
        check_int("reset_id", int'(bus_if.m_gnt_id), 0);
        check_int("reset_err", int'(bus_if.err_overflow), 0);

        // 1: port0 waits until port1 has an event
        base = gnt_seen;
        drive(2'b01, 2'b01);
        repeat (3) drive(2'b00, 2'b01);
        check_int("t1_no_grant", gnt_seen - base, 0);
        drive(2'b10, 2'b01);
        drive(2'b00, 2'b01);
        check_int("t1_gnt", int'(bus_if.m_gnt), 1);
        check_int("t1_id", int'(bus_if.m_gnt_id), 0);
        repeat (4) drive(2'b00, 2'b01);
        check_int("t1_count", gnt_seen - base, 1);

        // 2: alternating grants
        do_reset();
        seen_ids.delete();
        base = gnt_seen;
        repeat (3) drive(2'b11, 2'b00);
        repeat (16) drive(2'b00, 2'b11);
        check_int("t2_count", gnt_seen - base, 6);
        for (int i = 0; i < seen_ids.size() && i < 6; i++) check_int("t2_order", seen_ids[i], i % 2);

        // 3: increment and grant on the same edge
        do_reset();
        base = gnt_seen;
        drive(2'b11, 2'b01);
        drive(2'b11, 2'b01);
        repeat (6) drive(2'b00, 2'b01);
        check_int("t3_count", gnt_seen - base, 2);

        // 4: overflow at the window limit
        do_reset();
        base = gnt_seen;
        repeat (8) drive(2'b10, 2'b00);
        check_int("t4_err", int'(bus_if.err_overflow), 1);
        repeat (5) drive(2'b00, 2'b00);
        check_int("t4_err_sticky", int'(bus_if.err_overflow), 1);
        repeat (7) drive(2'b01, 2'b00);
        repeat (20) drive(2'b00, 2'b10);
        check_int("t4_count", gnt_seen - base, 7);
        check_int("t4_err_end", int'(bus_if.err_overflow), 1);

        // 6: reset while a grant is on the wire
        do_reset();
        repeat (8) drive(2'b10, 2'b00);
        drive(2'b01, 2'b00);
        drive(2'b00, 2'b10);
        check_int("t6_pre_gnt", int'(bus_if.m_gnt), 2);
        check_int("t6_pre_id", int'(bus_if.m_gnt_id), 1);
        check_int("t6_pre_err", int'(bus_if.err_overflow), 1);
        #1 rst = 1'b0;
        #1;
        check_int("t6_rst_gnt", int'(bus_if.m_gnt), 0);
        check_int("t6_rst_id", int'(bus_if.m_gnt_id), 0);
        check_int("t6_rst_err", int'(bus_if.err_overflow), 0);
        bus_if.m_req = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        base = gnt_seen;
        repeat (10) drive(2'b00, 2'b11);
        check_int("t6_no_grant", gnt_seen - base, 0);
        seen_ids.delete();
        drive(2'b11, 2'b00);
        repeat (5) drive(2'b00, 2'b11);
        check_int("t6_count", gnt_seen - base, 2);
        if (seen_ids.size() > 0) check_int("t6_first_id", seen_ids[0], 0);

        // 5: counter wrap
        do_reset();
        base = gnt_seen;
        for (int n = 0; n < 40; n++) begin
            drive(2'b11, 2'b11);
            repeat (3) drive(2'b00, 2'b11);
        end
        repeat (6) drive(2'b00, 2'b11);
        check_int("t5_count", gnt_seen - base, 80);
        check_int("t5_err", int'(bus_if.err_overflow), 0);

        // Randomized traffic
        do_reset();
        for (int blk = 0; blk < 6; blk++) begin
            pct = (blk % 3 == 0) ? 20 : ((blk % 3 == 1) ? 50 : 85);
            for (int c = 0; c < 100; c++) begin
                for (int j = 0; j < P; j++) inc[j] = ($urandom_range(0, 99) < pct);
                drive(inc, P'($urandom_range(0, (1 << P) - 1)));
            end
        end
        repeat (4) drive(2'b00, 2'b00);
        check_int("queue_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
